ringosc_meas_ctrl: RTL and testbench

Measurement controller for the 5-stage sky130 ring oscillator. On request it enables the oscillator, waits a settle interval, counts rising edges of the (pre-divided) oscillator output over a programmable window of reference clocks, then disables the oscillator and returns the count with a done pulse. It sits between the ring-oscillator macro (plus its external divider) and the digital readout/config logic.

---
 rtl/ringosc_pkg.sv | 20 ++
 rtl/ringosc_sync.sv | 32 +++
 rtl/ringosc_meas_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_ringosc_meas_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/ringosc_pkg.sv
// ringosc_pkg: shared types and defaults for the ring-oscillator measurement
// controller (FSM state encoding, default widths, settle length, averaging shift).
package ringosc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_COUNT  = 2'd2,
        ST_DONE   = 2'd3
    } ringosc_state_e;

    localparam int RINGOSC_CNT_W         = 16;
    localparam int RINGOSC_WIN_W         = 16;
    localparam int RINGOSC_SETTLE_CYCLES = 8;
    localparam int RINGOSC_SYNC_STAGES   = 2;

    // Averaging runs 2**RINGOSC_AVG_SHIFT windows and divides by shifting.
    localparam int RINGOSC_AVG_SHIFT     = 2;

endpackage : ringosc_pkg

// File: rtl/ringosc_sync.sv
// ringosc_sync: brings the asynchronous divided oscillator output into the clk
// domain through a SYNC_STAGES flop chain, then emits a registered one-cycle
// pulse for every rising edge of the synchronized signal.
// Edge-to-pulse latency is SYNC_STAGES+1 clk cycles.
module ringosc_sync
    import ringosc_pkg::*;
#(
    parameter int SYNC_STAGES = RINGOSC_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic osc_i,
    output logic edge_o
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sync_d_r;

    // Synchronizer chain, delayed copy of its output and registered edge pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r   <= {SYNC_STAGES{1'b0}};
            sync_d_r <= 1'b0;
            edge_o   <= 1'b0;
        end else begin
            sync_r   <= {sync_r[SYNC_STAGES-2:0], osc_i};
            sync_d_r <= sync_r[SYNC_STAGES-1];
            edge_o   <= sync_r[SYNC_STAGES-1] & ~sync_d_r;
        end
    end

endmodule : ringosc_sync

// File: rtl/ringosc_meas_ctrl.sv
// ringosc_meas_ctrl: measurement controller for the ring oscillator.
// On start it enables the oscillator, waits SETTLE_CYCLES, counts synchronized
// rising edges over win_len reference clocks, disables the oscillator and
// presents the saturating count with a one-cycle done pulse.
// Optional build macro RINGOSC_MEAS_AVG_EN: count four back-to-back windows
// into a wider accumulator and report the truncated average.
// SETTLE_CYCLES must be >= SYNC_STAGES+1 so the synchronizer is flushed before
// counting starts.
module ringosc_meas_ctrl
    import ringosc_pkg::*;
#(
    parameter int CNT_W         = RINGOSC_CNT_W,
    parameter int WIN_W         = RINGOSC_WIN_W,
    parameter int SETTLE_CYCLES = RINGOSC_SETTLE_CYCLES,
    parameter int SYNC_STAGES   = RINGOSC_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [WIN_W-1:0] win_len_i,
    input  logic             osc_i,
    output logic             osc_en_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] count_o,
    output logic             ovf_o
);

    // One timer serves both the settle interval and the count window.
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam int TMR_W = (WIN_W > SET_W) ? WIN_W : SET_W;

    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);

    ringosc_state_e   state_r,   state_s;
    logic [TMR_W-1:0] tmr_r,     tmr_s;
    logic [WIN_W-1:0] win_len_r, win_len_s;
    logic [CNT_W-1:0] cnt_r,     cnt_s;
    logic             ovf_r,     ovf_s;
    logic [CNT_W-1:0] cnt_inc_s;
    logic             ovf_inc_s;
    logic [CNT_W-1:0] res_cnt_s;
    logic             res_ovf_s;
    logic             win_end_s;
    logic             edge_s;

`ifdef RINGOSC_MEAS_AVG_EN
    localparam int                       ACC_W    = CNT_W + RINGOSC_AVG_SHIFT;
    localparam logic [RINGOSC_AVG_SHIFT-1:0] WIN_LAST = {RINGOSC_AVG_SHIFT{1'b1}};

    logic [ACC_W-1:0]             acc_r,     acc_s;
    logic [ACC_W-1:0]             acc_sum_s;
    logic [CNT_W-1:0]             acc_avg_s;
    logic [RINGOSC_AVG_SHIFT-1:0] win_idx_r, win_idx_s;
`endif

    ringosc_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .osc_i  (osc_i),
        .edge_o (edge_s)
    );

    // Last cycle of the current count window (win_len_r is nonzero in COUNT)
    assign win_end_s = (tmr_r == (TMR_W'(win_len_r) - TMR_W'(1)));

    // Saturating increment of the edge counter for this cycle's edge pulse
    always_comb begin
        cnt_inc_s = cnt_r;
        ovf_inc_s = ovf_r;
        if (edge_s) begin
            if (cnt_r == CNT_MAX) begin
                ovf_inc_s = 1'b1;
            end else begin
                cnt_inc_s = cnt_r + CNT_W'(1);
            end
        end else begin
            cnt_inc_s = cnt_r;
            ovf_inc_s = ovf_r;
        end
    end

`ifdef RINGOSC_MEAS_AVG_EN
    // Window accumulation and truncating average of the four windows
    always_comb begin
        acc_sum_s = acc_r + ACC_W'(cnt_inc_s);
        acc_avg_s = acc_sum_s[ACC_W-1:RINGOSC_AVG_SHIFT];
    end
`endif

    // Next-state, datapath update and result selection
    always_comb begin
        state_s   = state_r;
        tmr_s     = tmr_r;
        win_len_s = win_len_r;
        cnt_s     = cnt_r;
        ovf_s     = ovf_r;
        res_cnt_s = count_o;
        res_ovf_s = ovf_o;
`ifdef RINGOSC_MEAS_AVG_EN
        acc_s     = acc_r;
        win_idx_s = win_idx_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (start_i) begin
                    win_len_s = win_len_i;
                    tmr_s     = TMR_W'(0);
                    cnt_s     = CNT_W'(0);
                    ovf_s     = 1'b0;
`ifdef RINGOSC_MEAS_AVG_EN
                    acc_s     = ACC_W'(0);
                    win_idx_s = {RINGOSC_AVG_SHIFT{1'b0}};
`endif
                    if (win_len_i != WIN_W'(0)) begin
                        state_s = ST_SETTLE;
                    end else begin
                        state_s   = ST_DONE;
                        res_cnt_s = CNT_W'(0);
                        res_ovf_s = 1'b0;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (abort_i) begin
                    state_s = ST_IDLE;
                end else if (tmr_r == SETTLE_LAST) begin
                    state_s = ST_COUNT;
                    tmr_s   = TMR_W'(0);
                end else begin
                    tmr_s = tmr_r + TMR_W'(1);
                end
            end
            ST_COUNT: begin
                cnt_s = cnt_inc_s;
                ovf_s = ovf_inc_s;
                if (abort_i) begin
                    // Abort wins over a coincident window end.
                    state_s = ST_IDLE;
                end else if (win_end_s) begin
`ifdef RINGOSC_MEAS_AVG_EN
                    acc_s = acc_sum_s;
                    tmr_s = TMR_W'(0);
                    cnt_s = CNT_W'(0);
                    if (win_idx_r == WIN_LAST) begin
                        state_s   = ST_DONE;
                        res_cnt_s = acc_avg_s;
                        res_ovf_s = ovf_inc_s;
                    end else begin
                        win_idx_s = win_idx_r + {{(RINGOSC_AVG_SHIFT-1){1'b0}}, 1'b1};
                    end
`else
                    state_s   = ST_DONE;
                    res_cnt_s = cnt_inc_s;
                    res_ovf_s = ovf_inc_s;
`endif
                end else begin
                    tmr_s = tmr_r + TMR_W'(1);
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            tmr_r     <= TMR_W'(0);
            win_len_r <= WIN_W'(0);
            cnt_r     <= CNT_W'(0);
            ovf_r     <= 1'b0;
`ifdef RINGOSC_MEAS_AVG_EN
            acc_r     <= ACC_W'(0);
            win_idx_r <= {RINGOSC_AVG_SHIFT{1'b0}};
`endif
        end else begin
            state_r   <= state_s;
            tmr_r     <= tmr_s;
            win_len_r <= win_len_s;
            cnt_r     <= cnt_s;
            ovf_r     <= ovf_s;
`ifdef RINGOSC_MEAS_AVG_EN
            acc_r     <= acc_s;
            win_idx_r <= win_idx_s;
`endif
        end
    end

    // Registered outputs decoded from the next state so they align with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            osc_en_o <= 1'b0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            count_o  <= CNT_W'(0);
            ovf_o    <= 1'b0;
        end else begin
            osc_en_o <= (state_s == ST_SETTLE) || (state_s == ST_COUNT);
            busy_o   <= (state_s == ST_SETTLE) || (state_s == ST_COUNT);
            done_o   <= (state_s == ST_DONE);
            count_o  <= res_cnt_s;
            ovf_o    <= res_ovf_s;
        end
    end

endmodule : ringosc_meas_ctrl

// File: tb/tb_ringosc_meas_ctrl.sv
// tb_ringosc_meas_ctrl: randomized self-checking bench. A full-width instance
// and a 4-bit-counter instance share the same stimulus; a reference model
// derives windows, done timing and counts from the recorded oscillator rises.
module tb_ringosc_meas_ctrl;

    localparam int S     = 8;    // settle cycles
    localparam int LAT   = 3;    // edge-to-count latency (sync stages + 1)
    localparam int CMAXS = 15;   // saturation value of the 4-bit instance
`ifdef RINGOSC_MEAS_AVG_EN
    localparam int NWIN  = 4;
`else
    localparam int NWIN  = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic        abort_i = 1'b0;
    logic [15:0] win_len_i = 16'd0;
    logic        osc_i = 1'b0;

    logic        osc_en_o, busy_o, done_o, ovf_o;
    logic [15:0] count_o;
    logic        sm_osc_en, sm_busy, sm_done, sm_ovf;
    logic [3:0]  sm_count;

    ringosc_meas_ctrl #(.CNT_W(16), .WIN_W(16), .SETTLE_CYCLES(S), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
        .win_len_i(win_len_i), .osc_i(osc_i), .osc_en_o(osc_en_o),
        .busy_o(busy_o), .done_o(done_o), .count_o(count_o), .ovf_o(ovf_o)
    );

    ringosc_meas_ctrl #(.CNT_W(4), .WIN_W(16), .SETTLE_CYCLES(S), .SYNC_STAGES(2)) dut_small (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
        .win_len_i(win_len_i), .osc_i(osc_i), .osc_en_o(sm_osc_en),
        .busy_o(sm_busy), .done_o(sm_done), .count_o(sm_count), .ovf_o(sm_ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Free-running divided oscillator; rises are logged with their cycle number
    int osc_period = 10;
    int osc_phase  = 0;
    int rises[$];
    initial begin
        logic nv;
        forever begin
            @(negedge clk);
            #($urandom_range(1, 4));
            osc_phase = (osc_phase + 1) % osc_period;
            nv = (osc_phase < osc_period / 2);
            if (nv && !osc_i) rises.push_back(cyc);
            osc_i = nv;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input longint obs, input longint exp, input int tol);
        checks++;
        if (obs > exp + tol || obs < exp - tol) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (tol %0d) at cycle %0d", tag, obs, exp, tol, cyc);
        end
    endtask

    // Reference model state: last completed results
    int m_cnt = 0;
    int m_cnt_s = 0;
    bit m_ovf_s = 1'b0;
    bit m_ovf_s_known = 1'b1;

    function automatic int win_count(input int lo, input int hi);
        int n = 0;
        foreach (rises[i]) if (rises[i] + LAT >= lo && rises[i] + LAT <= hi) n++;
        return n;
    endfunction

    task automatic start_meas(input int w, output int acc);
        win_len_i = 16'(w);
        start_i = 1'b1;
        acc = cyc;
        rises.delete();
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic check_results();
        check_val("count_hold", count_o, m_cnt, 1);
        check_val("ovf_hold", ovf_o, 0, 0);
        check_val("count_s_hold", sm_count, m_cnt_s, 1);
        if (m_ovf_s_known) check_val("ovf_s_hold", sm_ovf, m_ovf_s, 0);
    endtask

    // Per-cycle check of one measurement that was accepted in cycle acc
    task automatic monitor(input int acc, input int w, input int abort_off, input bit hold);
        int wtot, done_exp, last, abort_cyc, lo, hi, c, sum_b, sum_s;
        bit aborted, exp_en, exp_done, ov_s, unsure;
        wtot = NWIN * w;
        done_exp = (w == 0) ? acc + 1 : acc + S + wtot + 1;
        last = done_exp + 2;
        aborted = 1'b0;
        abort_cyc = 0;
        while (cyc <= last) begin
            exp_en = (w != 0) && (cyc > acc) && (cyc <= acc + S + wtot) && !(aborted && cyc > abort_cyc);
            exp_done = (cyc == done_exp) && !aborted;
            check_val("osc_en", osc_en_o, exp_en, 0);
            check_val("busy", busy_o, exp_en, 0);
            check_val("done", done_o, exp_done, 0);
            check_val("osc_en_s", sm_osc_en, exp_en, 0);
            check_val("done_s", sm_done, exp_done, 0);
            if (exp_done) begin
                sum_b = 0; sum_s = 0; ov_s = 1'b0; unsure = 1'b0;
                for (int k = 0; k < NWIN; k++) begin
                    lo = acc + S + 1 + k * w;
                    hi = lo + w - 1;
                    c = win_count(lo, hi);
                    sum_b += c;
                    sum_s += (c > CMAXS) ? CMAXS : c;
                    if (c > CMAXS) ov_s = 1'b1;
                    if (c >= CMAXS - 1 && c <= CMAXS + 2) unsure = 1'b1;
                end
                m_cnt = sum_b / NWIN;
                m_cnt_s = sum_s / NWIN;
                m_ovf_s = ov_s;
                m_ovf_s_known = !unsure;
                check_results();
            end
            abort_i = 1'b0;
            start_i = 1'b0;
            if (abort_off > 0 && cyc == acc + abort_off) begin
                abort_i = 1'b1;
                aborted = 1'b1;
                abort_cyc = cyc;
            end
            if (hold && !aborted && cyc == done_exp) start_i = 1'b1;
            @(negedge clk);
        end
        check_results();
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_osc_en"}, osc_en_o, 0, 0);
        check_val({tag, "_busy"}, busy_o, 0, 0);
        check_val({tag, "_done"}, done_o, 0, 0);
        check_val({tag, "_count"}, count_o, 0, 0);
        check_val({tag, "_ovf"}, ovf_o, 0, 0);
        check_val({tag, "_count_s"}, sm_count, 0, 0);
        check_val({tag, "_ovf_s"}, sm_ovf, 0, 0);
    endtask

    initial begin
        int acc, w, ab;
        bit hold;

        // Reset state
        repeat (3) @(negedge clk);
        check_all_zero("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // Zero-length window: done next cycle, count 0, oscillator never enabled
        start_meas(0, acc);
        monitor(acc, 0, 0, 1'b0);

        // Period 10, W=100: about 10 edges per window
        osc_period = 10;
        start_meas(100, acc);
        monitor(acc, 100, 0, 1'b0);
        check_val("tp1_count", count_o, 10, 1);

        // Abort 50 cycles in: no done, previous result held
        start_meas(100, acc);
        monitor(acc, 100, 50, 1'b0);
        check_val("abort_held", count_o, 10, 1);

        // Abort coincident with the last count cycle: abort wins
        start_meas(20, acc);
        monitor(acc, 20, S + NWIN * 20, 1'b0);

        // Saturation on the 4-bit instance
        osc_period = 4;
        start_meas(200, acc);
        monitor(acc, 200, 0, 1'b1);
        check_val("tp2_count_s", sm_count, 15, 0);
        check_val("tp2_ovf_s", sm_ovf, 1, 0);

        // Reset mid-COUNT with start held high through and after reset
        osc_period = 10;
        start_meas(100, acc);
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        start_i = 1'b1;
        #1;
        check_all_zero("midrst");
        repeat (3) @(negedge clk);
        check_all_zero("midrst_hold");
        m_cnt = 0; m_cnt_s = 0; m_ovf_s = 1'b0; m_ovf_s_known = 1'b1;
        rst_n = 1'b1;
        win_len_i = 16'd100;
        acc = cyc;
        rises.delete();
        @(negedge clk);
        start_i = 1'b0;
        monitor(acc, 100, 0, 1'b0);

        // Randomized measurements
        for (int t = 0; t < 14; t++) begin
            osc_period = $urandom_range(4, 24);
            w = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 150);
            ab = ($urandom_range(0, 3) == 0 && w != 0) ? $urandom_range(1, S + NWIN * w) : 0;
            hold = 1'($urandom_range(0, 1));
            start_meas(w, acc);
            monitor(acc, w, ab, hold);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_ringosc_meas_ctrl
